// File: rtl/memory_responder_if.sv
// memory_responder_if: processor memory bus, program-load port and boot
// status outputs. The responder uses the slave view; the loader/processor
// side uses the master view.
interface memory_responder_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) ();
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] out;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  cpu_rst_n;
    logic                  running;

    modport slave (
        input  we, addr, data, load_valid, load_data, load_last,
        output out, load_ready, cpu_rst_n, running
    );

    modport master (
        output we, addr, data, load_valid, load_data, load_last,
        input  out, load_ready, cpu_rst_n, running
    );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: single-port RAM behind the processor memory bus with a
// boot sequencer. After reset it zeroes every word (CLEAR), then accepts a
// program image from the loader (LOAD), then releases the processor and
// services its reads/writes with read-first, one-cycle latency (RUN).
module memory_responder #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    memory_responder_if.slave   bus
);
    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_load_ready;
    logic                  r_cpu_rst_n;
    logic                  r_running;

    logic                  w_accept;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // Pick the single RAM write port source: clear pointer, loader, or processor.
    always_comb begin
        w_accept    = (r_state == ST_LOAD) && r_load_ready && bus.load_valid;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_ptr;
        w_mem_wdata = '0;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we = 1'b1;
            end
            ST_LOAD: begin
                w_mem_we    = w_accept;
                w_mem_wdata = bus.load_data;
            end
            ST_RUN: begin
                w_mem_we    = bus.we;
                w_mem_addr  = bus.addr;
                w_mem_wdata = bus.data;
            end
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
    end

    // RAM array; contents are not reset, the CLEAR phase zeroes them instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Boot sequencer with registered status outputs and read-first data out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_CLEAR;
            r_ptr        <= '0;
            r_out        <= '0;
            r_load_ready <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == PTR_LAST) begin
                        r_state      <= ST_LOAD;
                        r_load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (bus.load_last || (r_ptr == PTR_LAST)) begin
                            r_state      <= ST_RUN;
                            r_load_ready <= 1'b0;
                            r_cpu_rst_n  <= 1'b1;
                            r_running    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_out <= r_mem[bus.addr];
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign bus.out        = r_out;
    assign bus.load_ready = r_load_ready;
    assign bus.cpu_rst_n  = r_cpu_rst_n;
    assign bus.running    = r_running;
endmodule
